player_command_decoder: RTL and testbench



---
 rtl/player_command_decoder.sv | 163 ++++++++++++++++
 tb/tb_player_command_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_command_decoder.sv
// player_command_decoder: validates UART player command bytes, tracks lane and
// projectile type, turns the level-coded fire bit into rate-limited fire pulses,
// and raises a one-cycle game reset request.
// Optional feature macro: LINK_TIMEOUT_EN compiles in the link watchdog and the
// STALE state. Without it, link_up holds from the first valid frame until rst.
module player_command_decoder #(
    parameter logic [3:0]  DEFAULT_LANE   = 4'd5,
    parameter logic [15:0] FIRE_COOLDOWN  = 16'd50000,
    parameter logic [26:0] TIMEOUT_CYCLES = 27'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] lane,
    output logic       projectile_type,
    output logic       fire_pulse,
    output logic       game_reset,
    output logic       frame_error,
    output logic [7:0] err_count,
    output logic       link_up
);

    // Elaboration-time parameter sanity checks.
    if (DEFAULT_LANE == 4'd0 || DEFAULT_LANE > 4'd9) begin : g_bad_lane
        $error("DEFAULT_LANE must be in 1..9");
    end
    if (TIMEOUT_CYCLES == 27'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef LINK_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_STALE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE} state_e;
`endif

    state_e      state_q, state_d;
    logic [3:0]  lane_q, lane_d;
    logic        proj_q, proj_d;
    logic        fire_q, fire_d;
    logic        grst_q, grst_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  err_q, err_d;
    logic        link_q, link_d;
    logic        prev_fire_q, prev_fire_d;
    // [7] of the last valid frame; a reset request fires only on its rising edge
    logic        prev_rr_q, prev_rr_d;
    logic [15:0] cool_q, cool_d;
`ifdef LINK_TIMEOUT_EN
    logic [26:0] wd_q, wd_d;
`endif

    logic frame_ok;
    logic rr_edge;

    assign frame_ok = rx_valid && !rx_data[6] && (rx_data[3:0] <= 4'd9);
    assign rr_edge  = frame_ok && rx_data[7] && !prev_rr_q;

    // Next-state and registered-output computation for every command byte.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        proj_d      = proj_q;
        fire_d      = 1'b0;
        grst_d      = 1'b0;
        ferr_d      = 1'b0;
        err_d       = err_q;
        prev_fire_d = prev_fire_q;
        prev_rr_d   = prev_rr_q;
        cool_d      = (cool_q != 16'd0) ? cool_q - 16'd1 : 16'd0;
`ifdef LINK_TIMEOUT_EN
        wd_d        = (wd_q != 27'd0) ? wd_q - 27'd1 : 27'd0;
`endif

        // Rejected bytes only bump the error counter; nothing else moves.
        if (rx_valid && !frame_ok) begin
            ferr_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end

        if (frame_ok) begin
            state_d   = S_ACTIVE;
            prev_rr_d = rx_data[7];
`ifdef LINK_TIMEOUT_EN
            // Loaded with T-1 so the counter reads zero exactly T cycles later.
            wd_d      = TIMEOUT_CYCLES - 27'd1;
`endif
            if (rr_edge) begin
                grst_d      = 1'b1;
                lane_d      = DEFAULT_LANE;
                proj_d      = 1'b0;
                cool_d      = 16'd0;
                prev_fire_d = 1'b0;
            end else if (rx_data[7]) begin
                // Held reset request: lane and fire (including prev_fire) frozen.
                proj_d = rx_data[4];
            end else begin
                lane_d      = (rx_data[3:0] == 4'd0) ? DEFAULT_LANE : rx_data[3:0];
                proj_d      = rx_data[4];
                prev_fire_d = rx_data[5];
                // Edges inside the cooldown window are dropped, not queued.
                if (rx_data[5] && !prev_fire_q && cool_q == 16'd0) begin
                    fire_d = 1'b1;
                    cool_d = FIRE_COOLDOWN;
                end
            end
        end
`ifdef LINK_TIMEOUT_EN
        else if (state_q == S_ACTIVE && wd_q == 27'd0) begin
            state_d     = S_STALE;
            lane_d      = DEFAULT_LANE;
            prev_fire_d = 1'b0;
        end
`endif

        link_d = (state_d == S_ACTIVE);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lane_q      <= DEFAULT_LANE;
            proj_q      <= 1'b0;
            fire_q      <= 1'b0;
            grst_q      <= 1'b0;
            ferr_q      <= 1'b0;
            err_q       <= 8'd0;
            link_q      <= 1'b0;
            prev_fire_q <= 1'b0;
            prev_rr_q   <= 1'b0;
            cool_q      <= 16'd0;
`ifdef LINK_TIMEOUT_EN
            wd_q        <= 27'd0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            proj_q      <= proj_d;
            fire_q      <= fire_d;
            grst_q      <= grst_d;
            ferr_q      <= ferr_d;
            err_q       <= err_d;
            link_q      <= link_d;
            prev_fire_q <= prev_fire_d;
            prev_rr_q   <= prev_rr_d;
            cool_q      <= cool_d;
`ifdef LINK_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign lane            = lane_q;
    assign projectile_type = proj_q;
    assign fire_pulse      = fire_q;
    assign game_reset      = grst_q;
    assign frame_error     = ferr_q;
    assign err_count       = err_q;
    assign link_up         = link_q;

endmodule

// File: tb/tb_player_command_decoder.sv
// Testbench for player_command_decoder: directed scenarios plus a randomized
// stream compared against a cycle-indexed behavioural model.
module tb_player_command_decoder;

    localparam logic [3:0] DL = 4'd5;
    localparam int FC = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] lane;
    logic       projectile_type, fire_pulse, game_reset, frame_error, link_up;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state
    logic [3:0] m_lane;
    logic       m_proj, m_fire, m_grst, m_ferr, m_link, m_prev_fire, m_rr_held;
    int         m_err;
    int         m_ok_from;     // first edge cycle at which a fire edge is accepted
    int         m_last_valid;  // edge cycle of the last valid frame

    player_command_decoder #(
        .DEFAULT_LANE(DL),
        .FIRE_COOLDOWN(16'(FC)),
        .TIMEOUT_CYCLES(27'(TO))
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .lane(lane), .projectile_type(projectile_type), .fire_pulse(fire_pulse),
        .game_reset(game_reset), .frame_error(frame_error),
        .err_count(err_count), .link_up(link_up)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] act_vec();
        return {lane, projectile_type, fire_pulse, game_reset, frame_error, err_count, link_up};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_lane, m_proj, m_fire, m_grst, m_ferr, m_err[7:0], m_link};
    endfunction

    // Drive one cycle, advance the model at that edge, release inputs after it.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic vf;
        rst = r; rx_valid = v; rx_data = d;
        @(posedge clk);
        cyc++;
        m_fire = 0; m_grst = 0; m_ferr = 0;
        if (r) begin
            m_lane = DL; m_proj = 0; m_link = 0; m_prev_fire = 0; m_rr_held = 0;
            m_err = 0; m_ok_from = 0; m_last_valid = cyc;
        end else begin
            vf = v && !d[6] && (d[3:0] <= 4'd9);
            if (v && !vf) begin
                m_ferr = 1;
                if (m_err < 255) m_err++;
            end
            if (vf) begin
                m_link = 1;
                m_last_valid = cyc;
                if (d[7] && !m_rr_held) begin
                    m_grst = 1; m_lane = DL; m_proj = 0; m_prev_fire = 0; m_ok_from = 0;
                end else if (d[7]) begin
                    m_proj = d[4];
                end else begin
                    m_lane = (d[3:0] == 0) ? DL : d[3:0];
                    m_proj = d[4];
                    if (d[5] && !m_prev_fire && cyc >= m_ok_from) begin
                        m_fire = 1;
                        m_ok_from = cyc + 1 + FC;
                    end
                    m_prev_fire = d[5];
                end
                m_rr_held = d[7];
            end
`ifdef LINK_TIMEOUT_EN
            else if (m_link && (cyc - m_last_valid) >= TO) begin
                m_link = 0; m_lane = DL; m_prev_fire = 0;
            end
`endif
        end
        #1;
        rst = 0; rx_valid = 0; rx_data = 8'h00;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00);
        checks++;
        if (act_vec() !== {DL, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", act_vec(), {DL, 13'd0});
        end
    endtask

    task automatic test_first_frame();
        step(1, 0, 8'h00);
        step(0, 1, 8'h07);
        checks++;
        if (lane !== 4'd7) begin failures++; $display("FAIL first_lane got=%0d exp=7", lane); end
        checks++;
        if (link_up !== 1'b1) begin failures++; $display("FAIL first_link got=%b exp=1", link_up); end
        checks++;
        if (frame_error !== 1'b0) begin failures++; $display("FAIL first_ferr got=%b exp=0", frame_error); end
    endtask

    task automatic test_lane_invalid();
        logic [7:0] d;
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        checks++;
        if (lane !== DL) begin failures++; $display("FAIL lane0_default got=%0d exp=%0d", lane, DL); end
        step(0, 1, 8'h4A);
        checks++;
        if ({frame_error, lane} !== {1'b1, DL}) begin
            failures++; $display("FAIL inv_4A got ferr=%b lane=%0d exp ferr=1 lane=5", frame_error, lane);
        end
        step(0, 1, 8'h0C);
        checks++;
        if ({frame_error, lane, err_count} !== {1'b1, DL, 8'd2}) begin
            failures++;
            $display("FAIL inv_0C got ferr=%b lane=%0d err=%0d exp 1/5/2", frame_error, lane, err_count);
        end
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            if ($urandom % 2 == 0) d[6] = 1'b1;
            else d[3:0] = 4'($urandom_range(10, 15));
            step(0, 1, d);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL inv_stream i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (err_count !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
    endtask

    task automatic test_fire_cooldown();
        step(1, 0, 8'h00);
        step(0, 1, 8'h23);
        checks++;
        if ({fire_pulse, lane} !== {1'b1, 4'd3}) begin
            failures++; $display("FAIL fire_first got pulse=%b lane=%0d exp 1/3", fire_pulse, lane);
        end
        step(0, 1, 8'h03);    // cycle P
        step(0, 0, 8'h00);    // P+1
        step(0, 1, 8'h23);    // P+2: inside cooldown
        checks++;
        if (fire_pulse !== 1'b0) begin failures++; $display("FAIL fire_p2_drop got=%b exp=0", fire_pulse); end
        step(0, 1, 8'h03);    // P+3
        step(0, 1, 8'h23);    // P+4: first accepted cycle
        checks++;
        if (fire_pulse !== 1'b1) begin failures++; $display("FAIL fire_p4_accept got=%b exp=1", fire_pulse); end
        // one cycle short of the window must still drop
        step(0, 1, 8'h03);    // new P
        step(0, 0, 8'h00);
        step(0, 1, 8'h03);
        step(0, 1, 8'h23);    // P+3
        checks++;
        if (fire_pulse !== 1'b0) begin failures++; $display("FAIL fire_p3_drop got=%b exp=0", fire_pulse); end
        step(0, 1, 8'h03);
        step(0, 1, 8'h23);
        checks++;
        if (fire_pulse !== 1'b1) begin failures++; $display("FAIL fire_after_window got=%b exp=1", fire_pulse); end
    endtask

    task automatic test_reset_request();
        step(1, 0, 8'h00);
        step(0, 1, 8'h17);
        step(0, 1, 8'hA2);
        checks++;
        if ({game_reset, lane, fire_pulse, projectile_type} !== {1'b1, DL, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rr_edge got grst=%b lane=%0d fire=%b proj=%b exp 1/5/0/0",
                     game_reset, lane, fire_pulse, projectile_type);
        end
        step(0, 1, 8'h96);
        checks++;
        if ({game_reset, lane, projectile_type} !== {1'b0, DL, 1'b1}) begin
            failures++;
            $display("FAIL rr_held got grst=%b lane=%0d proj=%b exp 0/5/1", game_reset, lane, projectile_type);
        end
        step(0, 1, 8'h06);
        checks++;
        if ({game_reset, lane, projectile_type} !== {1'b0, 4'd6, 1'b0}) begin
            failures++;
            $display("FAIL rr_release got grst=%b lane=%0d proj=%b exp 0/6/0", game_reset, lane, projectile_type);
        end
    endtask

    task automatic test_rst_collision();
        step(1, 0, 8'h00);
        step(0, 1, 8'h07);
        step(0, 1, 8'h4F);
        step(1, 1, 8'h29);
        checks++;
        if (act_vec() !== {DL, 13'd0}) begin
            failures++; $display("FAIL rst_collision got=%h exp=%h", act_vec(), {DL, 13'd0});
        end
        step(0, 0, 8'h00);
        checks++;
        if (act_vec() !== {DL, 13'd0}) begin
            failures++; $display("FAIL rst_collision_after got=%h exp=%h", act_vec(), {DL, 13'd0});
        end
    endtask

    task automatic test_link();
        step(1, 0, 8'h00);
        step(0, 1, 8'h08);
`ifdef LINK_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step(0, 0, 8'h00);
            checks++;
            if (link_up !== 1'b1) begin failures++; $display("FAIL wd_early i=%0d got=%b exp=1", i, link_up); end
        end
        step(0, 0, 8'h00);
        checks++;
        if ({link_up, lane} !== {1'b0, DL}) begin
            failures++; $display("FAIL wd_expire got link=%b lane=%0d exp 0/5", link_up, lane);
        end
        step(0, 1, 8'h02);
        checks++;
        if ({link_up, lane} !== {1'b1, 4'd2}) begin
            failures++; $display("FAIL wd_recover got link=%b lane=%0d exp 1/2", link_up, lane);
        end
`else
        for (int i = 0; i < 3 * TO; i++) step(0, 0, 8'h00);
        checks++;
        if ({link_up, lane} !== {1'b1, 4'd8}) begin
            failures++; $display("FAIL link_hold got link=%b lane=%0d exp 1/8", link_up, lane);
        end
`endif
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] d;
        logic v, r;
        step(1, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 400 == 0) begin
                for (int k = 0; k < TO + 10; k++) step(0, 0, 8'h00);
            end
            r = ($urandom % 300 == 0);
            v = ($urandom % 4 != 0);
            d = 8'($urandom);
            if ($urandom % 8 != 0) d[6] = 1'b0;
            if ($urandom % 8 != 0) d[7] = 1'b0;
            d[3:0] = 4'($urandom_range(0, 11));
            step(r, v, d);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_step i=%0d d=%h v=%b r=%b got=%h exp=%h", i, d, v, r, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_first_frame();
        test_lane_invalid();
        test_fire_cooldown();
        test_reset_request();
        test_rst_collision();
        test_link();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
